digit_scan_decoder: RTL and testbench
=====================================

# digit_scan_decoder

Parametrised, clocked digit-scan decoder for the lock's multiplexed seven-segment display. It replaces the fixed 2-to-4 combinational digit select with a free-running scan counter driving an N-way one-hot digit select. The block also muxes the matching 4-bit code out of a packed digit bus, decodes it to segments, and adds blanking and per-digit blinking. It sits between the lock controller (which supplies digit codes and blink mask) and the display pins.

## Interface
- N_DIG, 6, number of digits scanned; legal 2..16
- SCAN_DIV, 1000, CLK cycles per digit slot; legal ≥1
- BLINK_DIV, 250, full scan rounds per blink half-period; legal ≥1
- ACTIVE_LOW, 1, 1: DIG and SEG active-low (common-anode); 0: active-high
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- EN_N  input  1  active-low enable; 1 blanks all digits
- DATA  input  4*N_DIG  packed codes; digit k = DATA[4k+3:4k], digit 0 = DIG[0]
- BLINK  input  N_DIG  per-digit blink mask
- DIG  output  N_DIG  one-hot digit select (polarity per ACTIVE_LOW)
- SEG  output  7  segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
- IDX  output  ceil(log2(N_DIG))  index of digit currently driven

## Operation
- Prescaler `pre`: counts 0..SCAN_DIV-1 and wraps. `tick` = (pre == SCAN_DIV-1). SCAN_DIV=1 gives a tick every cycle.
- Digit index `idx`: advances on `tick`, 0..N_DIG-1, then wraps to 0. It never holds a value ≥ N_DIG, including for non-power-of-2 N_DIG.
- Blink: `rnd` counts completed scans. It advances on `tick` when idx == N_DIG-1 and wraps at BLINK_DIV-1. `phase` toggles when `rnd` wraps.
- Output logic, registered, computed from the current idx/DATA/EN_N/BLINK/phase:
  - `active` = !EN_N && !(BLINK[idx] && phase).
  - DIG (logical) = active ? (1 << idx) : 0.
  - SEG (logical) = active ? hex7(DATA[idx]) : 0.
  - IDX = idx.
  - Physical DIG and SEG are inverted when ACTIVE_LOW=1.
- hex7 covers the full 0–F range: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (logical, {g..a}).
- EN_N only gates outputs. pre, idx, rnd and phase keep running while blanked.
- At most one DIG bit is ever logically active. No glitch states occur because DIG and SEG update in the same register stage.

## Timing
- Reset (RST_N=0, asynchronous): pre=0, idx=0, rnd=0, phase=0.
  - Logical DIG=0 and SEG=0, so physical outputs are all-1 when ACTIVE_LOW=1 and all-0 when ACTIVE_LOW=0.
  - IDX=0.
- Reset mid-scan: all state returns to the reset values immediately. Scan restarts at digit 0 with a full SCAN_DIV slot.
- Latency: one cycle from idx, DATA, EN_N, BLINK or phase to DIG, SEG and IDX.
  - First rising edge after RST_N deasserts with EN_N=0 drives digit 0.
  - Digit 0 holds for exactly SCAN_DIV cycles; every digit slot is exactly SCAN_DIV cycles.
- Full scan period = N_DIG*SCAN_DIV cycles. Blink half-period = BLINK_DIV*N_DIG*SCAN_DIV cycles.
- DATA changes mid-slot are reflected on SEG the next cycle, with no wait for the next slot.
- EN_N 0→1: outputs blank on the next edge. EN_N 1→0: outputs resume on the next edge at the current idx, not at digit 0.
- Simultaneous idx wrap and rnd wrap on the same tick: idx→0, rnd→0 and phase toggles in that cycle. Digit 0 of the new round uses the new phase.

## Test plan
- Reset/scan: N_DIG=6, SCAN_DIV=4, ACTIVE_LOW=0, EN_N=0, DATA=0x543210, BLINK=0.
  - After release, DIG steps 01,02,04,08,10,20 and then 01, each held 4 cycles.
  - SEG = 3F,06,5B,4F,66,6D matching each digit; IDX = 0..5.
- Non-power-of-2 wrap: N_DIG=3, SCAN_DIV=1 → IDX sequence 0,1,2,0,1,2; DIG never 0 or multi-hot while EN_N=0.
- Blanking: assert EN_N=1 while idx=3 for 10 cycles, then release.
  - DIG=0 and SEG=0 one cycle after assertion.
  - On release, the digit shown is idx per the uninterrupted count (scan not restarted).
- Blink: N_DIG=6, SCAN_DIV=2, BLINK_DIV=2, BLINK=6'b000100.
  - Digit 2 is dark for 24-cycle windows alternating with lit 24-cycle windows.
  - Other digits are never dark.
- Polarity/hex: ACTIVE_LOW=1 with DATA digit 0 = 0xA, 0xF → SEG = ~77 = 0x08 and ~71 = 0x0E; DIG[0]=0 with all other DIG bits 1; under reset all outputs are 1.
- Async reset mid-slot: pulse RST_N low for half a cycle while idx=4.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, digit 0 is shown for SCAN_DIV cycles.

Source files
------------

// File: rtl/digit_scan_decoder.sv
// Multiplexed seven-segment digit scanner: a free-running prescaler and digit
// index drive a one-hot digit select, the matching 4-bit code is decoded to
// segments, and per-digit blinking plus a global blank gate the outputs.
module digit_scan_decoder #(
  parameter int unsigned N_DIG      = 6,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 250,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN_N,
  input  logic [4*N_DIG-1:0]         DATA,
  input  logic [N_DIG-1:0]           BLINK,
  output logic [N_DIG-1:0]           DIG,
  output logic [6:0]                 SEG,
  output logic [$clog2(N_DIG)-1:0]   IDX
);

  localparam int unsigned IW = $clog2(N_DIG);
  localparam int unsigned PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned RW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] RND_LAST = RW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RW-1:0]    rnd_q, rnd_d;
  logic             phase_q, phase_d;
  logic             tick;

  logic [N_DIG-1:0] dig_q, dig_d;
  logic [6:0]       seg_q, seg_d;
  logic [IW-1:0]    idx_out_q;

  logic [3:0]       code;
  logic             active;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick = (pre_q == PRE_LAST);

  // Next state for prescaler, digit index, scan-round counter and blink phase.
  // Counters keep running while blanked; only the outputs are gated.
  always_comb begin
    pre_d   = pre_q;
    idx_d   = idx_q;
    rnd_d   = rnd_q;
    phase_d = phase_q;
    if (tick) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          phase_d = ~phase_q;
        end else begin
          rnd_d = rnd_q + RW'(1);
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Scan state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q   <= '0;
      idx_q   <= '0;
      rnd_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      phase_q <= phase_d;
    end
  end

  // Logical digit/segment values for the digit currently indexed.
  always_comb begin
    code   = DATA[{idx_q, 2'b00} +: 4];
    active = !EN_N && !(BLINK[idx_q] && phase_q);
    dig_d  = '0;
    seg_d  = '0;
    if (active) begin
      dig_d = N_DIG'(1) << idx_q;
      seg_d = hex7(code);
    end
  end

  // Output register: DIG, SEG and IDX change on the same edge, so no
  // intermediate mismatched digit/segment combination reaches the pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dig_q     <= '0;
      seg_q     <= '0;
      idx_out_q <= '0;
    end else begin
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      idx_out_q <= idx_q;
    end
  end

  assign DIG = (ACTIVE_LOW != 0) ? ~dig_q : dig_q;
  assign SEG = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign IDX = idx_out_q;

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Directed bench for digit_scan_decoder: four instances cover the basic scan,
// a non-power-of-2 wrap, blinking and active-low polarity.
module tb_digit_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        en_n;
  logic [23:0] data;
  logic [23:0] data3;

  logic [5:0]  dig0, dig2, dig3;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic [2:0]  dig1;
  logic [2:0]  idx0, idx2, idx3;
  logic [1:0]  idx1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [6:0] seg_tab [6];

  digit_scan_decoder #(.N_DIG(6), .SCAN_DIV(4), .BLINK_DIV(250), .ACTIVE_LOW(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .EN_N(en_n), .DATA(data), .BLINK(6'b000000),
    .DIG(dig0), .SEG(seg0), .IDX(idx0));

  digit_scan_decoder #(.N_DIG(3), .SCAN_DIV(1), .BLINK_DIV(250), .ACTIVE_LOW(0)) u1 (
    .CLK(clk), .RST_N(rst_n), .EN_N(en_n), .DATA(data[11:0]), .BLINK(3'b000),
    .DIG(dig1), .SEG(seg1), .IDX(idx1));

  digit_scan_decoder #(.N_DIG(6), .SCAN_DIV(2), .BLINK_DIV(2), .ACTIVE_LOW(0)) u2 (
    .CLK(clk), .RST_N(rst_n), .EN_N(en_n), .DATA(data), .BLINK(6'b000100),
    .DIG(dig2), .SEG(seg2), .IDX(idx2));

  digit_scan_decoder #(.N_DIG(6), .SCAN_DIV(4), .BLINK_DIV(250), .ACTIVE_LOW(1)) u3 (
    .CLK(clk), .RST_N(rst_n), .EN_N(en_n), .DATA(data3), .BLINK(6'b000000),
    .DIG(dig3), .SEG(seg3), .IDX(idx3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dig0"}, 32'(dig0), 32'h0);
    chk({tag, "_seg0"}, 32'(seg0), 32'h0);
    chk({tag, "_idx0"}, 32'(idx0), 32'h0);
    chk({tag, "_dig3"}, 32'(dig3), 32'h3F);
    chk({tag, "_seg3"}, 32'(seg3), 32'h7F);
  endtask

  // Drive inputs for edge c (1 = first edge after reset release), take the
  // edge, then compare every instance against its hand-derived schedule.
  task automatic step(input int c, input bit blank);
    int   s0, s1, s2, ph;
    logic [6:0] seg3_log;
    en_n  = blank;
    data3 = (c >= 3) ? 24'h00000F : 24'h00000A;
    @(posedge clk);
    #1;
    s0 = ((c - 1) / 4) % 6;
    s1 = (c - 1) % 3;
    s2 = ((c - 1) / 2) % 6;
    ph = ((c - 1) / 24) % 2;

    chk($sformatf("u0_dig_c%0d", c), 32'(dig0), blank ? 32'h0 : 32'(1 << s0));
    chk($sformatf("u0_seg_c%0d", c), 32'(seg0), blank ? 32'h0 : 32'(seg_tab[s0]));
    chk($sformatf("u0_idx_c%0d", c), 32'(idx0), 32'(s0));

    chk($sformatf("u1_dig_c%0d", c), 32'(dig1), blank ? 32'h0 : 32'(1 << s1));
    chk($sformatf("u1_idx_c%0d", c), 32'(idx1), 32'(s1));

    chk($sformatf("u2_dig_c%0d", c), 32'(dig2),
        (blank || (s2 == 2 && ph == 1)) ? 32'h0 : 32'(1 << s2));

    seg3_log = (s0 == 0) ? ((c >= 3) ? 7'h71 : 7'h77) : 7'h3F;
    chk($sformatf("u3_dig_c%0d", c), 32'(dig3), blank ? 32'h3F : 32'(~(6'(1) << s0) & 6'h3F));
    chk($sformatf("u3_seg_c%0d", c), 32'(seg3), blank ? 32'h7F : 32'(~seg3_log & 7'h7F));
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B;
    seg_tab[3] = 7'h4F; seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D;

    rst_n = 1'b0;
    en_n  = 1'b0;
    data  = 24'h543210;
    data3 = 24'h00000A;

    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Scan, wrap, blink and polarity; blank for edges 61..70, entered while
    // the u0 index is 3 and left without restarting the scan.
    for (int c = 1; c <= 90; c++) begin
      step(c, (c >= 61 && c <= 70));
    end

    // After edge 90 u0 is mid-slot on digit 4; reset without any clock edge.
    chk("pre_async_idx0", 32'(idx0), 32'd4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    #4;
    rst_n = 1'b1;

    for (int c = 1; c <= 8; c++) begin
      step(c, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
